// File: rtl/hex_keypad_input.sv
// 4x4 active-low hex keypad scanner with press/release/enter debounce, a 16-bit
// digit entry register and a committed data register with valid/ack handshake.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// REL_QUAL   | waiting for DEBOUNCE_SCANS consecutive key-free scans
// IDLE       | released and armed, waiting for a single key
// PRESS_QUAL | counting consecutive scans that show the candidate key
// HELD       | digit accepted, waiting for the key to go away (no repeat)
module hex_keypad_input #(
   parameter int SCAN_DIV       = 24000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  col,
   input  logic        enter,
   input  logic        clear,
   input  logic        ack,
   output logic [3:0]  row,
   output logic [15:0] num,
   output logic [15:0] data,
   output logic        valid,
   output logic        key_strobe,
   output logic        overrun
);
   localparam int DW = $clog2(SCAN_DIV + 1);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 2);

   typedef enum logic [1:0] {REL_QUAL, IDLE, PRESS_QUAL, HELD} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
   logic [3:0]      cand, cand_nxt;
   logic [3:0]      col_m, col_s;
   logic            ent_m, ent_s;
   logic [DW-1:0]   div_cnt;
   logic [1:0]      r_idx;
   logic [11:0]     acc;
   logic [15:0]     scan_vec;
   logic [4:0]      hits;
   logic [3:0]      code;
   logic            single, row_last, tick, accept, commit;
   logic            enter_db;
   logic [CW-1:0]   ecnt, ecnt_inc;
   logic [15:0]     num_shift;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_m <= 4'hF;
         col_s <= 4'hF;
         ent_m <= 1'b0;
         ent_s <= 1'b0;
      end else begin
         col_m <= col;
         col_s <= col_m;
         ent_m <= enter;
         ent_s <= ent_m;
      end
   end

   assign row_last = (div_cnt == DW'(SCAN_DIV - 1));
   assign tick     = row_last && (r_idx == 2'd3);
   assign row      = ~(4'b0001 << r_idx);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         r_idx   <= 2'd0;
         acc     <= '0;
      end else if (row_last) begin
         div_cnt <= '0;
         r_idx   <= r_idx + 2'd1;
         if (r_idx != 2'd3) acc[r_idx*4 +: 4] <= ~col_s;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // Row 3 is judged straight from the synchroniser on the tick itself.
   assign scan_vec = {~col_s, acc};

   always_comb begin
      hits = 5'd0;
      code = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (scan_vec[i]) begin
            hits = hits + 5'd1;
            code = 4'(i);
         end
      end
   end

   assign single  = (hits == 5'd1);
   assign cnt_inc = cnt + CW'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= REL_QUAL;
         cnt   <= '0;
         cand  <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         cand  <= cand_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cand_nxt  = cand;
      if (tick) begin
         case (state)
            REL_QUAL: begin
               if (single) begin
                  cnt_nxt = '0;
               end else if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            IDLE: begin
               if (single) begin
                  cand_nxt  = code;
                  cnt_nxt   = CW'(1);
                  state_nxt = (DEBOUNCE_SCANS == 1) ? HELD : PRESS_QUAL;
               end
            end
            PRESS_QUAL: begin
               if (single && code == cand) begin
                  if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
                     state_nxt = HELD;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end
            end
            default: begin
               if (!(single && code == cand)) begin
                  state_nxt = (DEBOUNCE_SCANS == 1) ? IDLE : REL_QUAL;
                  cnt_nxt   = (DEBOUNCE_SCANS == 1) ? CW'(0) : CW'(1);
               end
            end
         endcase
      end
   end

   always_comb begin
      accept = 1'b0;
      if (tick && single) begin
         case (state)
            IDLE:       accept = (DEBOUNCE_SCANS == 1);
            PRESS_QUAL: accept = (code == cand) && (cnt_inc >= CW'(DEBOUNCE_SCANS));
            default:    accept = 1'b0;
         endcase
      end
   end

   assign ecnt_inc = ecnt + CW'(1);
   assign commit   = tick && ent_s && !enter_db && (ecnt_inc >= CW'(DEBOUNCE_SCANS));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enter_db <= 1'b0;
         ecnt     <= '0;
      end else if (tick) begin
         if (ent_s != enter_db) begin
            if (ecnt_inc >= CW'(DEBOUNCE_SCANS)) begin
               enter_db <= ent_s;
               ecnt     <= '0;
            end else begin
               ecnt <= ecnt_inc;
            end
         end else begin
            ecnt <= '0;
         end
      end
   end

   // A digit accepted on the commit tick is folded into the committed value.
   assign num_shift = {num[11:0], code};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num        <= '0;
         data       <= '0;
         valid      <= 1'b0;
         key_strobe <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         key_strobe <= accept && !clear;
         if (commit) begin
            data  <= accept ? num_shift : num;
            valid <= 1'b1;
            if (valid) overrun <= 1'b1;
         end else if (ack) begin
            valid <= 1'b0;
         end
         if (clear) begin
            num     <= '0;
            overrun <= 1'b0;
         end else if (commit) begin
            num <= '0;
         end else if (accept) begin
            num <= num_shift;
         end
      end
   end
endmodule

// File: doc/hex_keypad_input.md
Name: hex_keypad_input

Overview:
- Input-side peripheral: the operator-entry counterpart to the multiplexed seven-segment output path.
- Scans a 4x4 active-low hex keypad, debounces presses, and shifts hex digits into a 16-bit entry register. The entry register can drive the display.
- A debounced ENTER button commits the entry to a data register with a valid/ack handshake toward the processor.

Parameters:
- SCAN_DIV, 24000, clk cycles each row is driven (1 ms at 24 MHz).
- DEBOUNCE_SCANS, 4, consecutive full scans required to accept a press, a release or an enter level change (>=1).

Ports:
- clk  input  1  system clock, 24 MHz.
- reset  input  1  asynchronous, active-low reset.
- col  input  4  keypad columns, active-low, externally pulled up, asynchronous.
- enter  input  1  raw ENTER button, active-high, asynchronous.
- clear  input  1  synchronous, active-high; clears the entry register and overrun.
- ack  input  1  processor read strobe, one cycle, active-high.
- row  output  4  row drive, one-cold.
- num  output  16  live entry register, for the display.
- data  output  16  committed value.
- valid  output  1  data available.
- key_strobe  output  1  one-cycle pulse per accepted digit.
- overrun  output  1  sticky; set when a commit occurs while valid=1.

Behaviour:
- Reset values: row=4'b1110, num=0, data=0, valid=0, key_strobe=0, overrun=0, scan index 0, all counters 0, FSM in REL_QUAL.
- col and enter each pass through a 2-flop synchroniser.
- Scan:
  - Row index r runs 0..3; row drives bit r low and all other bits high.
  - Each row is held SCAN_DIV cycles. Synchronised col is sampled on the last cycle of the row, then r increments (wraps 3->0).
  - The scan tick is the cycle in which row 3 is sampled.
- Key code: the key at row r, column c (col bit c low) has code 4*r+c. The scan result is:
  - SINGLE(k) if exactly one of the 16 keys reads low;
  - NONE otherwise (zero keys or multiple keys; multiple presses are ignored).
- Enter is sampled once per scan tick.
- FSM, evaluated only on scan ticks, with counter cnt:
  - REL_QUAL: NONE -> cnt++, and on reaching DEBOUNCE_SCANS go to IDLE with cnt=0. Any key -> cnt=0.
  - IDLE: SINGLE(k) -> cand=k, cnt=1. If DEBOUNCE_SCANS=1, accept immediately and go to HELD; otherwise go to PRESS_QUAL.
  - PRESS_QUAL: SINGLE(cand) -> cnt++; at DEBOUNCE_SCANS, accept and go to HELD. Anything else -> IDLE, cnt=0.
  - HELD: SINGLE(cand) -> stay (no auto-repeat). Anything else -> REL_QUAL, cnt=1.
- Accept: num <= {num[11:0], cand}; the oldest digit is discarded. key_strobe=1 for the clock after the scan tick.
- Enter debounce: enter_db changes level only after DEBOUNCE_SCANS consecutive scan-tick samples that disagree with its current level.
- Commit on each 0->1 transition of enter_db:
  - data <= num, valid <= 1, num <= 0.
  - If valid was already 1, data is overwritten and overrun <= 1.
- Same scan tick, key accept and commit: the digit is shifted in first, the commit captures the shifted value, and num ends at 0.
- ack:
  - ack with valid=1 clears valid on the next clock; data holds its value.
  - ack with valid=0 has no effect.
  - ack and commit in the same cycle: the commit wins, valid stays 1 and data takes the new value.
- clear: num <= 0 and overrun <= 0 next clock; it has priority over key accept that cycle. It does not affect data or valid.
- Reset mid-operation: everything returns to reset values. A key held through reset is not accepted until DEBOUNCE_SCANS NONE scans have passed.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2; scan period 16 clk):
- Reset released, no keys -> row steps 1110,1101,1011,0111 every 4 clk; num=0, valid=0, key_strobe never asserts.
- Hold key row2/col1 for 12 scans -> exactly one key_strobe, at the end of the 2nd matching scan; num=0x0009; no repeat.
- Press and release 1, A, 2, F (each held 3 scans, released 3 scans), then press ENTER for 3 scans -> data=0x1A2F, valid=1, num=0. One-cycle ack -> valid=0 next clk, data unchanged.
- Key row0/col3 alternating 1 scan pressed / 1 scan released for 10 scans -> no strobe. Keys 5 and 6 held together for 6 scans -> no strobe, num unchanged.
- Commit 0x0003, then commit 0x0004 without ack -> data=0x0004, overrun=1. Next commit with ack in the same cycle -> valid stays 1. clear -> overrun=0, num=0.
- Reset asserted during PRESS_QUAL with key 7 held -> immediate reset values. Key still held after reset -> no strobe until 2 NONE scans pass and 2 fresh matching scans follow.
